// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl
// Description : Sequential WIDTH-bit adder built around one 4-bit ripple-carry
//               slice, one nibble per clock, LSB first, with valid/ready
//               handshakes. Optional subtract mode under RCA_SEQ_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NIB = WIDTH / 4;
    localparam int c_IW  = $clog2(c_NIB);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [c_IW-1:0]  r_idx;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_nib;
    logic [4:0]       w_c;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;

    // B is stored already inverted for subtract, so the slice only ever adds.
`ifdef RCA_SEQ_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    // Operands shift right each RUN cycle so the active nibble is always [3:0].
    assign w_c[0] = r_carry;
    generate
        for (genvar i = 0; i < 4; i++) begin : g_fa
            assign w_nib[i]  = r_a[i] ^ r_b[i] ^ w_c[i];
            assign w_c[i+1]  = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= w_b_load;
                        r_carry    <= w_carry_load;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_nib;
                    r_carry <= w_c[4];
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST) begin
                        r_cout      <= w_c[4];
                        r_ovf       <= w_c[3] ^ w_c[4];
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_seq_ctrl
// Description : Directed self-checking bench for rca_seq_ctrl at WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_ctrl;

    localparam int c_W = 16;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           cin;
`ifdef RCA_SEQ_SUB_EN
    logic           sub;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] sum;
    logic           cout;
    logic           ovf;

    int n_checks = 0;
    int n_pass   = 0;

    rca_seq_ctrl #(.WIDTH(c_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Accept one request, optionally keep a junk request asserted afterwards,
    // and measure the cycles until out_valid rises.
    task automatic start_op(input logic [c_W-1:0] va, input logic [c_W-1:0] vb,
                            input logic vcin, input logic vsub, input logic noise);
        int lat;
        @(negedge clk);
        a = va; b = vb; cin = vcin;
`ifdef RCA_SEQ_SUB_EN
        sub = vsub;
`else
        if (vsub) $display("subtract request skipped in add-only build");
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("accept_in_ready_low", {31'd0, in_ready}, 32'd0);
        if (noise) begin
            a = 16'h0F0F; b = 16'h3333; cin = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 32'd4);
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'h0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Carry ripples through every nibble.
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("ripple_sum", {16'd0, sum}, 32'h0000);
        check("ripple_cout", {31'd0, cout}, 32'd1);
        check("ripple_ovf", {31'd0, ovf}, 32'd0);
        drain();

        // Signed overflow, held under backpressure with a junk request pending.
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("ovf_sum", {16'd0, sum}, 32'h8000);
            check("ovf_cout", {31'd0, cout}, 32'd0);
            check("ovf_ovf", {31'd0, ovf}, 32'd1);
            check("ovf_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_junk", {31'd0, in_ready}, 32'd1);

`ifdef RCA_SEQ_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        check("sub_borrow_sum", {16'd0, sum}, 32'hFFFE);
        check("sub_borrow_cout", {31'd0, cout}, 32'd0);
        drain();
        start_op(16'h0009, 16'h0002, 1'b0, 1'b1, 1'b0);
        check("sub_sum", {16'd0, sum}, 32'h0007);
        check("sub_cout", {31'd0, cout}, 32'd1);
        drain();
`endif

        // Reset lands mid-operation at E0+2.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_sum", {16'd0, sum}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("abort_no_valid", seen, 32'd0);
        end
        start_op(16'h1234, 16'h1111, 1'b1, 1'b0, 1'b0);
        check("post_abort_sum", {16'd0, sum}, 32'h2346);
        check("post_abort_cout", {31'd0, cout}, 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
